// File: rtl/student_day_scheduler_if.sv
// Handshake bundle between the day scheduler and its driver:
// time ticks and activity requests in, schedule outputs back.
interface student_day_scheduler_if;
    logic       tick_en;
    logic [4:0] req;
    logic [4:0] grant;
    logic [4:0] hour;
    logic       alarm;
    logic       bus;
    logic       class_active;
    logic       day_done;
    logic [2:0] sched_state;

    modport master (
        output tick_en,
        output req,
        input  grant,
        input  hour,
        input  alarm,
        input  bus,
        input  class_active,
        input  day_done,
        input  sched_state
    );

    modport slave (
        input  tick_en,
        input  req,
        output grant,
        output hour,
        output alarm,
        output bus,
        output class_active,
        output day_done,
        output sched_state
    );
endinterface

// File: rtl/student_day_scheduler.sv
// Time-of-day sequencer and activity arbiter: tick/hour clock, alarm,
// commute and lecture windows, and held one-at-a-time activity grants.
module student_day_scheduler #(
    parameter int TICKS_PER_HOUR = 4,
    parameter int WAKE_HOUR      = 7,
    parameter int CLASS_START    = 9,
    parameter int CLASS_END      = 16,
    parameter int SLEEP_HOUR     = 23,
    parameter int MIN_HOLD       = 2
) (
    input  logic clk,
    input  logic rst_n,
    student_day_scheduler_if.slave sif
);

    localparam int TW = $clog2(TICKS_PER_HOUR);
    localparam int HW = $clog2(MIN_HOLD + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_HOUR - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(MIN_HOLD);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [4:0]    WAKE_H    = 5'(WAKE_HOUR);
    localparam logic [4:0]    CLASS_S_H = 5'(CLASS_START);
    localparam logic [4:0]    CLASS_E_H = 5'(CLASS_END);
    localparam logic [4:0]    SLEEP_H   = 5'(SLEEP_HOUR);

    typedef enum logic [2:0] {
        S_NIGHT   = 3'd0,
        S_COMMUTE = 3'd1,
        S_CLASS   = 3'd2,
        S_FREE    = 3'd3,
        S_HOLD    = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [4:0]    hour_q, hour_d;
    logic [4:0]    grant_q, grant_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [2:0]    rr_ptr_q, rr_ptr_d;
    logic          alarm_q, alarm_d;
    logic          day_done_q, day_done_d;

    logic          hour_edge;
    logic [4:0]    arb_grant;
    logic [2:0]    arb_ptr;
    logic          arb_found;
    logic [1:0]    arb_pos;
    logic [2:0]    arb_idx;

    // Tick and hour counters; hour_edge marks the cycle hour is rewritten.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        hour_d     = hour_q;
        hour_edge  = 1'b0;
        day_done_d = 1'b0;
        if (sif.tick_en) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d = '0;
                hour_edge  = 1'b1;
                if (hour_q == 5'd23) begin
                    hour_d     = 5'd0;
                    day_done_d = 1'b1;
                end else begin
                    hour_d = hour_q + 5'd1;
                end
            end else begin
                tick_cnt_d = tick_cnt_q + TW'(1);
            end
        end
    end

    // Hungry wins outright; otherwise rotate over bits 1..4 from rr_ptr.
    always_comb begin
        arb_grant = '0;
        arb_ptr   = rr_ptr_q;
        arb_found = 1'b0;
        arb_pos   = 2'(rr_ptr_q - 3'd1);
        arb_idx   = 3'd1;
        if (sif.req[0]) begin
            arb_grant = 5'b00001;
        end else begin
            for (int i = 0; i < 4; i++) begin
                arb_idx = {1'b0, arb_pos + 2'(i)} + 3'd1;
                if (!arb_found && sif.req[arb_idx]) begin
                    arb_found = 1'b1;
                    arb_grant = 5'b00001 << arb_idx;
                    if (arb_idx == 3'd4) begin
                        arb_ptr = 3'd1;
                    end else begin
                        arb_ptr = arb_idx + 3'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        hold_cnt_d = hold_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        alarm_d    = 1'b0;
        unique case (state_q)
            S_NIGHT: begin
                grant_d = '0;
                if (hour_edge && hour_d == WAKE_H) begin
                    state_d = S_COMMUTE;
                    alarm_d = 1'b1;
                end
            end
            S_COMMUTE: begin
                if (hour_edge && hour_d == CLASS_S_H) begin
                    state_d = S_CLASS;
                end
            end
            S_CLASS: begin
                grant_d = '0;
                if (hour_edge && hour_d == CLASS_E_H) begin
                    state_d = S_FREE;
                end
            end
            S_FREE: begin
                if (hour_edge && hour_d == SLEEP_H) begin
                    state_d = S_NIGHT;
                    grant_d = '0;
                end else if (|sif.req) begin
                    state_d    = S_HOLD;
                    grant_d    = arb_grant;
                    hold_cnt_d = HOLD_INIT;
                    rr_ptr_d   = arb_ptr;
                end
            end
            S_HOLD: begin
                // Bedtime preempts a hold even when it would expire now.
                if (hour_edge && hour_d == SLEEP_H) begin
                    state_d    = S_NIGHT;
                    grant_d    = '0;
                    hold_cnt_d = '0;
                end else if (sif.tick_en) begin
                    if (hold_cnt_q == HOLD_ONE) begin
                        state_d    = S_FREE;
                        grant_d    = '0;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_ONE;
                    end
                end
            end
            default: begin
                state_d = S_NIGHT;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_NIGHT;
            tick_cnt_q <= '0;
            hour_q     <= '0;
            grant_q    <= '0;
            hold_cnt_q <= '0;
            rr_ptr_q   <= 3'd1;
            alarm_q    <= 1'b0;
            day_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            hour_q     <= hour_d;
            grant_q    <= grant_d;
            hold_cnt_q <= hold_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            alarm_q    <= alarm_d;
            day_done_q <= day_done_d;
        end
    end

    assign sif.grant        = grant_q;
    assign sif.hour         = hour_q;
    assign sif.alarm        = alarm_q;
    assign sif.day_done     = day_done_q;
    assign sif.bus          = (state_q == S_COMMUTE);
    assign sif.class_active = (state_q == S_CLASS);
    assign sif.sched_state  = state_q;

endmodule
